// File: rtl/hazard_detect.sv
// hazard_detect: stall/flush controller for the 5-stage MIPS pipeline.
// Detects load-use and branch-operand hazards that forwarding cannot
// resolve, freezes PC and IF/ID, and bubbles ID/EX. It also flushes IF/ID on
// taken branches and jumps, and keeps saturating stall/flush cycle counters.
module hazard_detect #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read_EX,
    input  logic             reg_write_EX,
    input  logic [4:0]       reg_Rd_EX,
    input  logic             mem_read_MEM,
    input  logic [4:0]       reg_Rd_MEM,
    input  logic [4:0]       reg_Rs_ID,
    input  logic [4:0]       reg_Rt_ID,
    input  logic             uses_rt_ID,
    input  logic             branch_ID,
    input  logic             branch_taken_ID,
    input  logic             jump_ID,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;

    logic dep_ex;
    logic dep_mem;
    logic hz_lu;
    logic hz_ba;
    logic hz_bl2;
    logic hz_bl1;
    logic stall_det;

    // Register matches against the EX and MEM destinations; $0 never matches.
    always_comb begin
        dep_ex  = ((reg_Rd_EX == reg_Rs_ID) && (reg_Rs_ID != 5'd0))
                | (uses_rt_ID && (reg_Rd_EX == reg_Rt_ID) && (reg_Rt_ID != 5'd0));
        dep_mem = ((reg_Rd_MEM == reg_Rs_ID) && (reg_Rs_ID != 5'd0))
                | (uses_rt_ID && (reg_Rd_MEM == reg_Rt_ID) && (reg_Rt_ID != 5'd0));
        hz_lu     = mem_read_EX & dep_ex;
        hz_ba     = branch_ID & reg_write_EX & ~mem_read_EX & dep_ex;
        hz_bl2    = branch_ID & mem_read_EX & dep_ex;
        hz_bl1    = branch_ID & mem_read_MEM & dep_mem;
        stall_det = hz_lu | hz_ba | hz_bl1 | hz_bl2;
    end

    // Pipeline control: Mealy in IDLE, forced stall in HOLD, stall beats flush.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (reset) begin
            // Defaults already describe the normal flow forced during reset.
        end else if (state == HOLD || stall_det) begin
            // Branch outcome is ignored here: its operands are stale.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            if_id_flush = jump_ID | (branch_ID & branch_taken_ID);
        end
    end

    // State and counters: only a load feeding a branch needs the HOLD cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state        <= IDLE;
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (state == IDLE && stall_det && hz_bl2)
                state <= HOLD;
            else
                state <= IDLE;

            if (id_ex_bubble && stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + 1'b1;
            if (if_id_flush && flush_cycles != CNT_MAX)
                flush_cycles <= flush_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_detect.sv
// tb_hazard_detect: directed scenarios for hazard_detect. A second instance
// with 2-bit counters shares the stimulus and is used for saturation.
module tb_hazard_detect;

    logic        clk;
    logic        reset;
    logic        mem_read_EX;
    logic        reg_write_EX;
    logic [4:0]  reg_Rd_EX;
    logic        mem_read_MEM;
    logic [4:0]  reg_Rd_MEM;
    logic [4:0]  reg_Rs_ID;
    logic [4:0]  reg_Rt_ID;
    logic        uses_rt_ID;
    logic        branch_ID;
    logic        branch_taken_ID;
    logic        jump_ID;

    logic        pc_write, if_id_write, id_ex_bubble, if_id_flush;
    logic [31:0] stall_cycles, flush_cycles;
    logic        pc_write_s, if_id_write_s, id_ex_bubble_s, if_id_flush_s;
    logic [1:0]  stall_s, flush_s;

    logic [3:0]  ctl;
    assign ctl = {pc_write, if_id_write, id_ex_bubble, if_id_flush};

    localparam logic [3:0] RUN   = 4'b1100;
    localparam logic [3:0] STALL = 4'b0010;
    localparam logic [3:0] FLUSH = 4'b1101;

    int checks   = 0;
    int failures = 0;

    hazard_detect #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .mem_read_EX(mem_read_EX), .reg_write_EX(reg_write_EX), .reg_Rd_EX(reg_Rd_EX),
        .mem_read_MEM(mem_read_MEM), .reg_Rd_MEM(reg_Rd_MEM),
        .reg_Rs_ID(reg_Rs_ID), .reg_Rt_ID(reg_Rt_ID), .uses_rt_ID(uses_rt_ID),
        .branch_ID(branch_ID), .branch_taken_ID(branch_taken_ID), .jump_ID(jump_ID),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    hazard_detect #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset),
        .mem_read_EX(mem_read_EX), .reg_write_EX(reg_write_EX), .reg_Rd_EX(reg_Rd_EX),
        .mem_read_MEM(mem_read_MEM), .reg_Rd_MEM(reg_Rd_MEM),
        .reg_Rs_ID(reg_Rs_ID), .reg_Rt_ID(reg_Rt_ID), .uses_rt_ID(uses_rt_ID),
        .branch_ID(branch_ID), .branch_taken_ID(branch_taken_ID), .jump_ID(jump_ID),
        .pc_write(pc_write_s), .if_id_write(if_id_write_s), .id_ex_bubble(id_ex_bubble_s),
        .if_id_flush(if_id_flush_s), .stall_cycles(stall_s), .flush_cycles(flush_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; checks happen #1 later, well before
    // the next rising edge.
    task automatic clear_inputs();
        mem_read_EX = 0; reg_write_EX = 0; reg_Rd_EX = 0;
        mem_read_MEM = 0; reg_Rd_MEM = 0;
        reg_Rs_ID = 0; reg_Rt_ID = 0; uses_rt_ID = 0;
        branch_ID = 0; branch_taken_ID = 0; jump_ID = 0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        mem_read_EX = 1; reg_Rd_EX = 8; reg_Rs_ID = 8;   // LU pattern, masked by reset
        #1;
        checks++;
        if (ctl !== RUN) begin
            failures++; $display("FAIL reset_outputs: got %b want %b", ctl, RUN);
        end
        next_cycle();
        #1;
        checks++;
        if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
            failures++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_cycles);
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_load_use();
        apply_reset();
        mem_read_EX = 1; reg_Rd_EX = 8; reg_Rs_ID = 8; reg_Rt_ID = 2; uses_rt_ID = 1;
        #1;
        checks++;
        if (ctl !== STALL) begin
            failures++; $display("FAIL lu_stall: got %b want %b", ctl, STALL);
        end
        next_cycle();
        // lw moved to MEM, bubble in EX; add is not a branch so no stall.
        clear_inputs();
        mem_read_MEM = 1; reg_Rd_MEM = 8; reg_Rs_ID = 8; reg_Rt_ID = 2; uses_rt_ID = 1;
        #1;
        checks++;
        if (ctl !== RUN) begin
            failures++; $display("FAIL lu_release: got %b want %b", ctl, RUN);
        end
        checks++;
        if (stall_cycles !== 32'd1) begin
            failures++; $display("FAIL lu_count: got %0d want 1", stall_cycles);
        end
        next_cycle();
        #1;
        checks++;
        if (stall_cycles !== 32'd1 || flush_cycles !== 32'd0) begin
            failures++; $display("FAIL lu_count_after: got %0d/%0d want 1/0", stall_cycles, flush_cycles);
        end
    endtask

    task automatic test_zero_reg();
        apply_reset();
        mem_read_EX = 1; reg_Rd_EX = 0; reg_Rs_ID = 0; reg_Rt_ID = 0; uses_rt_ID = 1;
        branch_ID = 1; reg_write_EX = 1; mem_read_MEM = 1; reg_Rd_MEM = 0;
        #1;
        checks++;
        if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
            failures++; $display("FAIL zero_reg: got pc_write=%b bubble=%b want 1/0", pc_write, id_ex_bubble);
        end
        next_cycle();
        #1;
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++; $display("FAIL zero_reg_count: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_branch_after_load();
        apply_reset();
        mem_read_EX = 1; reg_Rd_EX = 9; branch_ID = 1; reg_Rs_ID = 9; branch_taken_ID = 1;
        #1;
        checks++;
        if (ctl !== STALL) begin
            failures++; $display("FAIL bl2_first: got %b want %b", ctl, STALL);
        end
        next_cycle();
        // HOLD cycle: lw now in MEM (BL1 also true).
        clear_inputs();
        mem_read_MEM = 1; reg_Rd_MEM = 9; branch_ID = 1; reg_Rs_ID = 9; branch_taken_ID = 1;
        #1;
        checks++;
        if (ctl !== STALL) begin
            failures++; $display("FAIL bl2_hold: got %b want %b", ctl, STALL);
        end
        next_cycle();
        // lw in WB; branch resolves taken.
        mem_read_MEM = 0; reg_Rd_MEM = 0;
        #1;
        checks++;
        if (ctl !== FLUSH) begin
            failures++; $display("FAIL bl2_flush: got %b want %b", ctl, FLUSH);
        end
        checks++;
        if (stall_cycles !== 32'd2) begin
            failures++; $display("FAIL bl2_stall_count: got %0d want 2", stall_cycles);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (ctl !== RUN || flush_cycles !== 32'd1 || stall_cycles !== 32'd2) begin
            failures++; $display("FAIL bl2_after: got ctl=%b flush=%0d stall=%0d want %b/1/2",
                                 ctl, flush_cycles, stall_cycles, RUN);
        end
    endtask

    task automatic test_hold_unconditional();
        apply_reset();
        mem_read_EX = 1; reg_Rd_EX = 12; branch_ID = 1; reg_Rt_ID = 12; uses_rt_ID = 1;
        next_cycle();
        // No hazard and a jump present: HOLD still stalls, no flush.
        clear_inputs();
        jump_ID = 1;
        #1;
        checks++;
        if (ctl !== STALL) begin
            failures++; $display("FAIL hold_forced: got %b want %b", ctl, STALL);
        end
        next_cycle();
        #1;
        checks++;
        if (ctl !== FLUSH) begin
            failures++; $display("FAIL hold_exit: got %b want %b", ctl, FLUSH);
        end
        clear_inputs();
    endtask

    task automatic test_branch_alu();
        apply_reset();
        reg_write_EX = 1; reg_Rd_EX = 10; branch_ID = 1; reg_Rs_ID = 3; reg_Rt_ID = 10; uses_rt_ID = 1;
        #1;
        checks++;
        if (ctl !== STALL) begin
            failures++; $display("FAIL ba_stall: got %b want %b", ctl, STALL);
        end
        next_cycle();
        reg_write_EX = 0; reg_Rd_EX = 0;
        #1;
        checks++;
        if (ctl !== RUN || stall_cycles !== 32'd1) begin
            failures++; $display("FAIL ba_release: got ctl=%b stall=%0d want %b/1", ctl, stall_cycles, RUN);
        end
        next_cycle();
        reg_write_EX = 1; reg_Rd_EX = 10; uses_rt_ID = 0;
        #1;
        checks++;
        if (ctl !== RUN) begin
            failures++; $display("FAIL ba_rt_unused: got %b want %b", ctl, RUN);
        end
        next_cycle();
        // BL1 alone: load in MEM feeding branch rs.
        clear_inputs();
        mem_read_MEM = 1; reg_Rd_MEM = 3; branch_ID = 1; reg_Rs_ID = 3;
        #1;
        checks++;
        if (ctl !== STALL) begin
            failures++; $display("FAIL bl1_stall: got %b want %b", ctl, STALL);
        end
        next_cycle();
        clear_inputs();
        branch_ID = 1; reg_Rs_ID = 3;
        #1;
        checks++;
        if (ctl !== RUN || stall_cycles !== 32'd2) begin
            failures++; $display("FAIL bl1_release: got ctl=%b stall=%0d want %b/2", ctl, stall_cycles, RUN);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_jump_priority();
        apply_reset();
        jump_ID = 1;
        #1;
        checks++;
        if (ctl !== FLUSH) begin
            failures++; $display("FAIL jump_flush: got %b want %b", ctl, FLUSH);
        end
        next_cycle();
        jump_ID = 1; mem_read_EX = 1; reg_Rd_EX = 5; reg_Rs_ID = 5;
        #1;
        checks++;
        if (ctl !== STALL) begin
            failures++; $display("FAIL stall_over_flush: got %b want %b", ctl, STALL);
        end
        checks++;
        if (flush_cycles !== 32'd1) begin
            failures++; $display("FAIL jump_flush_count: got %0d want 1", flush_cycles);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (stall_cycles !== 32'd1 || flush_cycles !== 32'd1) begin
            failures++; $display("FAIL priority_counts: got %0d/%0d want 1/1", stall_cycles, flush_cycles);
        end
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        mem_read_EX = 1; reg_Rd_EX = 9; branch_ID = 1; reg_Rs_ID = 9;
        next_cycle();
        // In HOLD now; reset aborts it.
        clear_inputs();
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== RUN) begin
            failures++; $display("FAIL hold_reset_force: got %b want %b", ctl, RUN);
        end
        next_cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== RUN || stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
            failures++; $display("FAIL hold_reset_after: got ctl=%b stall=%0d flush=%0d want %b/0/0",
                                 ctl, stall_cycles, flush_cycles, RUN);
        end
    endtask

    task automatic test_saturation();
        int exp_s;
        apply_reset();
        mem_read_EX = 1; reg_Rd_EX = 7; reg_Rs_ID = 7;
        for (int n = 1; n <= 5; n++) begin
            next_cycle();
            #1;
            exp_s = (n > 3) ? 3 : n;
            checks++;
            if (stall_s !== exp_s[1:0] || stall_cycles !== n) begin
                failures++; $display("FAIL saturate_%0d: got narrow=%0d wide=%0d want %0d/%0d",
                                     n, stall_s, stall_cycles, exp_s, n);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_after_load();
        test_hold_unconditional();
        test_branch_alu();
        test_jump_priority();
        test_reset_mid_hold();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
